// File: rtl/pll_lock_sequencer.sv
// PLL power-up / relock sequencer on the free-running reference clock.
// Resets the PLL, waits for lock with timeout and retry, qualifies stability.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked_i,
  input  logic       relock_req_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int M1 =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX =
    (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic [1:0]    sync_q;
  logic          pll_rst_q, sys_rst_q, ready_q, fault_q;
  logic          locked_s;

  assign locked_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (relock_req_i) begin
          state_d = S_RESET;
        end else if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == RETRY_LIM) ? S_FAULT : S_RESET;
        end
      end
      S_STABLE: begin
        if (relock_req_i || !locked_s) begin
          state_d = S_RESET;
        end else if (cnt_q == ST_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        // A loss coinciding with relock is still counted.
        if (!locked_s && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        if (relock_req_i || !locked_s) state_d = S_RESET;
      end
      S_FAULT: begin
        if (relock_req_i) begin
          state_d = S_RESET;
          retry_d = '0;
        end
      end
      default: state_d = S_RESET;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b00;
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pll_locked_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == S_RESET) || (state_d == S_FAULT);
      sys_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign sys_rst_o       = sys_rst_q;
  assign ready_o         = ready_q;
  assign fault_o         = fault_q;
  assign state_o         = state_q;
  assign retry_cnt_o     = retry_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scenario bench for pll_lock_sequencer with short timing parameters.
// Expected timings are derived arithmetically from the sequencing rules.
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int TO = 20;
  localparam int SC = 8;
  localparam int MR = 3;
  localparam int LOCK_LAT = RC + 1 + SC;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       relock = 1'b0;
  logic       pll_rst_o, sys_rst_o, ready_o, fault_o;
  logic [2:0] state_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;

  int checks = 0;
  int failures = 0;
  int exp_loss = 0;
  logic [18:0] rst_vals = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 8'd0};

  pll_lock_sequencer #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(TO),
    .STABLE_CYCLES(SC), .MAX_RETRY(MR)
  ) dut (
    .refclk(refclk), .rst(rst),
    .pll_locked_i(locked), .relock_req_i(relock),
    .pll_rst_o(pll_rst_o), .sys_rst_o(sys_rst_o),
    .ready_o(ready_o), .fault_o(fault_o),
    .state_o(state_o), .retry_cnt_o(retry_cnt_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic logic [18:0] outs();
    return {pll_rst_o, sys_rst_o, ready_o, fault_o,
            state_o, retry_cnt_o, lock_loss_cnt_o};
  endfunction

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; relock = 1'b0;
    repeat (3) tick();
    checks++;
    if (outs() !== rst_vals) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", outs(), rst_vals);
    end
  endtask

  task automatic test_nominal();
    int n;
    int sq[$];
    logic [2:0] last;
    sq.push_back(int'(state_o));
    last = state_o;
    rst = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      if (state_o !== last) begin sq.push_back(int'(state_o)); last = state_o; end
    end while (pll_rst_o === 1'b1 && n < 50);
    checks++;
    if (n != RC) begin
      failures++;
      $display("FAIL nominal_pll_rst_len got=%0d exp=%0d", n, RC);
    end
    repeat (5) begin
      tick();
      if (state_o !== last) begin sq.push_back(int'(state_o)); last = state_o; end
    end
    locked = 1'b1;
    n = 0;
    do begin
      tick(); n++;
      if (state_o !== last) begin sq.push_back(int'(state_o)); last = state_o; end
    end while (ready_o !== 1'b1 && n < 60);
    checks++;
    if (n != 2 + 1 + SC) begin
      failures++;
      $display("FAIL nominal_lock_latency got=%0d exp=%0d", n, 2 + 1 + SC);
    end
    checks++;
    if (sys_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL nominal_sys_rst got=%b exp=0", sys_rst_o);
    end
    checks++;
    if (sq.size() != 4 || sq[0] != 0 || sq[1] != 1 ||
        sq[2] != 2 || sq[3] != 3) begin
      failures++;
      $display("FAIL nominal_state_seq got=%p exp=0,1,2,3", sq);
    end
  endtask

  task automatic test_relock_run();
    int n;
    relock = 1'b1;
    tick();
    relock = 1'b0;
    checks++;
    if ({state_o, ready_o, lock_loss_cnt_o} !== {3'd0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL relock_run got st=%0d rdy=%b loss=%0d exp st=0 rdy=0 loss=0",
               state_o, ready_o, lock_loss_cnt_o);
    end
    n = 0;
    do begin tick(); n++; end while (ready_o !== 1'b1 && n < 60);
    checks++;
    if (n != LOCK_LAT) begin
      failures++;
      $display("FAIL relock_run_latency got=%0d exp=%0d", n, LOCK_LAT);
    end
  endtask

  task automatic test_unstable();
    int n;
    bit saw_ready;
    rst = 1'b1; locked = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (pll_rst_o === 1'b1 && n < 50);
    repeat ($urandom_range(1, 10)) tick();
    locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (state_o !== 3'd2 && n < 20);
    checks++;
    if (state_o !== 3'd2) begin
      failures++;
      $display("FAIL unstable_enter_stable got=%0d exp=2", state_o);
    end
    repeat (4) tick();
    locked = 1'b0;
    saw_ready = 1'b0;
    repeat (3) begin tick(); if (ready_o) saw_ready = 1'b1; end
    checks++;
    if (state_o !== 3'd0) begin
      failures++;
      $display("FAIL unstable_back_to_reset got=%0d exp=0", state_o);
    end
    locked = 1'b1;
    checks++;
    if ({lock_loss_cnt_o, retry_cnt_o} !== {8'd0, 4'd0}) begin
      failures++;
      $display("FAIL unstable_counters got loss=%0d retry=%0d exp 0 0",
               lock_loss_cnt_o, retry_cnt_o);
    end
    n = 0;
    do begin tick(); n++; end while (ready_o !== 1'b1 && n < 60);
    checks++;
    if (saw_ready || n != LOCK_LAT) begin
      failures++;
      $display("FAIL unstable_relock got early=%b lat=%0d exp early=0 lat=%0d",
               saw_ready, n, LOCK_LAT);
    end
  endtask

  task automatic test_loss_run();
    int n;
    exp_loss = 0;
    for (int it = 0; it < 260; it++) begin
      repeat ($urandom_range(0, 5)) tick();
      locked = 1'b0;
      n = 0;
      do begin tick(); n++; end while (ready_o === 1'b1 && n < 10);
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      checks++;
      if (n != 3 || sys_rst_o !== 1'b1 || state_o !== 3'd0) begin
        failures++;
        $display("FAIL loss_drop it=%0d got lat=%0d sys_rst=%b st=%0d exp 3 1 0",
                 it, n, sys_rst_o, state_o);
      end
      checks++;
      if (int'(lock_loss_cnt_o) != exp_loss) begin
        failures++;
        $display("FAIL loss_count it=%0d got=%0d exp=%0d",
                 it, lock_loss_cnt_o, exp_loss);
      end
      repeat ($urandom_range(1, 6)) tick();
      locked = 1'b1;
      n = 0;
      do begin tick(); n++; end while (ready_o !== 1'b1 && n < 60);
      checks++;
      if (ready_o !== 1'b1) begin
        failures++;
        $display("FAIL loss_relock it=%0d got ready=%b exp=1", it, ready_o);
      end
    end
  endtask

  task automatic test_timeout();
    rst = 1'b1; locked = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 1; i <= MR * (RC + TO); i++) begin
      tick();
      if (i % (RC + TO) == 0 && i < MR * (RC + TO)) begin
        checks++;
        if (int'(retry_cnt_o) != i / (RC + TO) || state_o !== 3'd0) begin
          failures++;
          $display("FAIL timeout_retry at=%0d got retry=%0d st=%0d exp %0d 0",
                   i, retry_cnt_o, state_o, i / (RC + TO));
        end
      end
      if (i == MR * (RC + TO) - 1) begin
        checks++;
        if (fault_o !== 1'b0) begin
          failures++;
          $display("FAIL timeout_early_fault got=%b exp=0", fault_o);
        end
      end
    end
    checks++;
    if ({fault_o, state_o, retry_cnt_o, pll_rst_o} !==
        {1'b1, 3'd4, 4'(MR), 1'b1}) begin
      failures++;
      $display("FAIL timeout_fault got f=%b st=%0d r=%0d prst=%b exp 1 4 %0d 1",
               fault_o, state_o, retry_cnt_o, pll_rst_o, MR);
    end
    repeat (10) tick();
    checks++;
    if ({fault_o, state_o, pll_rst_o} !== {1'b1, 3'd4, 1'b1}) begin
      failures++;
      $display("FAIL timeout_hold got f=%b st=%0d prst=%b exp 1 4 1",
               fault_o, state_o, pll_rst_o);
    end
  endtask

  task automatic test_fault_recovery();
    int n;
    locked = 1'b1;
    repeat (3) tick();
    checks++;
    if (state_o !== 3'd4) begin
      failures++;
      $display("FAIL fault_sticky got=%0d exp=4", state_o);
    end
    relock = 1'b1;
    tick();
    relock = 1'b0;
    checks++;
    if ({fault_o, retry_cnt_o, state_o} !== {1'b0, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL fault_clear got f=%b r=%0d st=%0d exp 0 0 0",
               fault_o, retry_cnt_o, state_o);
    end
    n = 0;
    do begin tick(); n++; end while (ready_o !== 1'b1 && n < 60);
    checks++;
    if (n != LOCK_LAT) begin
      failures++;
      $display("FAIL fault_to_run got=%0d exp=%0d", n, LOCK_LAT);
    end
  endtask

  task automatic test_async_reset();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (state_o !== 3'd2 && n < 30);
    tick(); tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== rst_vals) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", outs(), rst_vals);
    end
    tick();
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (pll_rst_o === 1'b1 && n < 50);
    checks++;
    if (n != RC) begin
      failures++;
      $display("FAIL async_pll_rst_len got=%0d exp=%0d", n, RC);
    end
    n = 0;
    do begin tick(); n++; end while (ready_o !== 1'b1 && n < 60);
    checks++;
    if (n != 1 + SC) begin
      failures++;
      $display("FAIL async_resequence got=%0d exp=%0d", n, 1 + SC);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_relock_run();
    test_unstable();
    test_loss_run();
    test_timeout();
    test_fault_recovery();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
